// File: rtl/rover_led_sequencer.sv
// rover_led_sequencer: Avalon-MM slave that replays up to eight 8-bit
// patterns onto the LED PIO s1 port as single-cycle writes, once or looping.
module rover_led_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [1:0]  pio_address,
  output logic [31:0] pio_writedata
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_e;

  state_e          state_q, state_d;
  logic            run_q, run_d;
  logic            loop_q, loop_d;
  logic [2:0]      last_q, last_d;
  logic [23:0]     period_q, period_d;
  logic            done_q, done_d;
  logic [2:0]      idx_q, idx_d;
  logic [23:0]     cnt_q, cnt_d;
  logic [7:0][7:0] pat_q, pat_d;
  logic [7:0]      hold_q, hold_d;   // last pattern sent, kept on the bus between strobes

  logic wr, wr_ctrl, wr_period, wr_status, wr_pat, abort, busy;

  assign wr        = chipselect & ~write_n;
  assign wr_ctrl   = wr && (address == 4'd0);
  assign wr_period = wr && (address == 4'd1);
  assign wr_status = wr && (address == 4'd2);
  assign wr_pat    = wr && address[3];
  assign busy      = (state_q != S_IDLE);
  // A CTRL write with RUN=0 while a sequence is active stops it without DONE
  assign abort     = wr_ctrl && !writedata[0] && busy;

  // State register and all software-visible registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      run_q    <= 1'b0;
      loop_q   <= 1'b0;
      last_q   <= 3'd0;
      period_q <= 24'd0;
      done_q   <= 1'b0;
      idx_q    <= 3'd0;
      cnt_q    <= 24'd0;
      pat_q    <= '0;
      hold_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      loop_q   <= loop_d;
      last_q   <= last_d;
      period_q <= period_d;
      done_q   <= done_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      pat_q    <= pat_d;
      hold_q   <= hold_d;
    end
  end

  // Register writes and sequencer next-state; DONE set is applied last so it beats a clear
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    loop_d   = loop_q;
    last_d   = last_q;
    period_d = period_q;
    done_d   = done_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    pat_d    = pat_q;
    hold_d   = hold_q;

    if (wr_pat)                    pat_d[address[2:0]] = writedata[7:0];
    if (wr_period)                 period_d = writedata[23:0];
    if (wr_status && writedata[8]) done_d = 1'b0;
    if (wr_ctrl) begin
      loop_d = writedata[1];
      last_d = writedata[6:4];
    end

    case (state_q)
      S_IDLE: begin
        if (wr_ctrl && writedata[0]) begin
          run_d   = 1'b1;
          idx_d   = 3'd0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // The strobe in this cycle always completes, even on abort
        hold_d = pat_q[idx_q];
        if (abort) begin
          run_d   = 1'b0;
          idx_d   = 3'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d   = (period_q == 24'd0) ? 24'd1 : period_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          run_d   = 1'b0;
          idx_d   = 3'd0;
          state_d = S_IDLE;
        end else if (cnt_q == 24'd1) begin
          if (idx_q < last_q) begin
            idx_d   = idx_q + 3'd1;
            state_d = S_LOAD;
          end else if (loop_q) begin
            idx_d   = 3'd0;
            state_d = S_LOAD;
          end else begin
            done_d  = 1'b1;
            run_d   = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Zero-wait-state read mux
  always_comb begin
    readdata = 32'd0;
    case (address)
      4'd0:    readdata = {25'd0, last_q, 2'd0, loop_q, run_q};
      4'd1:    readdata = {8'd0, period_q};
      4'd2:    readdata = {23'd0, done_q, 1'b0, idx_q, 3'd0, busy};
      default: if (address[3]) readdata = {24'd0, pat_q[address[2:0]]};
    endcase
  end

  // PIO strobe is decoded straight from LOAD so reset drops it immediately
  assign pio_chipselect = (state_q == S_LOAD);
  assign pio_write_n    = (state_q != S_LOAD);
  assign pio_address    = 2'd0;
  assign pio_writedata  = {24'd0, (state_q == S_LOAD) ? pat_q[idx_q] : hold_q};

endmodule

// File: tb/tb_rover_led_sequencer.sv
// Directed bench for rover_led_sequencer: register map, one-shot, loop,
// abort, DONE clear and asynchronous reset mid-run.
module tb_rover_led_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = 4'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        pio_chipselect, pio_write_n;
  logic [1:0]  pio_address;
  logic [31:0] pio_writedata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] sdat[$];
  int          scyc[$];

  rover_led_sequencer dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .pio_chipselect(pio_chipselect), .pio_write_n(pio_write_n),
    .pio_address(pio_address), .pio_writedata(pio_writedata));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: data and cycle of every PIO write
  always @(negedge clk)
    if (reset_n && pio_chipselect && !pio_write_n) begin
      sdat.push_back(pio_writedata);
      scyc.push_back(cyc);
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; write is taken on the following posedge
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1 d = readdata;
    chipselect = 1'b0;
  endtask

  logic [31:0] r;
  int n, n0, k;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cs", {31'd0, pio_chipselect}, 32'd0);
    chk("rst_wn", {31'd0, pio_write_n}, 32'd1);
    chk("rst_wd", pio_writedata, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      rd(a[3:0], r);
      chk($sformatf("rst_reg%0d", a), r, 32'd0);
    end
    chk("rst_pa", {30'd0, pio_address}, 32'd0);

    // Unused bits and unmapped addresses
    wr(4'd3, 32'hFFFF_FFFF);
    rd(4'd3, r);  chk("unmapped", r, 32'd0);
    wr(4'd1, 32'hFFFF_FFFF);
    rd(4'd1, r);  chk("period_bits", r, 32'h00FF_FFFF);
    wr(4'd15, 32'hFFFF_FF5A);
    rd(4'd15, r); chk("pat_bits", r, 32'h0000_005A);

    // One-shot: 3 patterns, PERIOD=3
    wr(4'd8, 32'h01); wr(4'd9, 32'h02); wr(4'd10, 32'h04);
    wr(4'd1, 32'd3);
    wr(4'd0, 32'h21);
    n = cyc;
    repeat (11) @(negedge clk);
    rd(4'd2, r); chk("os_busy_n11", r, 32'h021);
    @(negedge clk);
    rd(4'd2, r); chk("os_done_n12", r, 32'h120);
    repeat (4) @(negedge clk);
    chk("os_cnt", sdat.size(), 3);
    if (sdat.size() == 3) begin
      chk("os_d0", sdat[0], 32'h01);
      chk("os_d1", sdat[1], 32'h02);
      chk("os_d2", sdat[2], 32'h04);
      chk("os_first", scyc[0], n);
      chk("os_sp1", scyc[1] - scyc[0], 4);
      chk("os_sp2", scyc[2] - scyc[1], 4);
    end
    rd(4'd0, r); chk("os_ctrl", r, 32'h20);
    chk("os_wd_hold", pio_writedata, 32'h04);

    // DONE clear, then repeat the one-shot
    wr(4'd2, 32'h100);
    rd(4'd2, r); chk("done_clr", r, 32'h020);
    wr(4'd0, 32'h21);
    repeat (14) @(negedge clk);
    rd(4'd2, r); chk("done_again", r, 32'h120);
    wr(4'd2, 32'h100);

    // Loop: PERIOD=0, two patterns
    sdat.delete(); scyc.delete();
    wr(4'd8, 32'hAA); wr(4'd9, 32'h55);
    wr(4'd1, 32'd0);
    wr(4'd0, 32'h13);
    repeat (24) @(negedge clk);
    chk("lp_cnt_ge10", {31'd0, sdat.size() >= 10}, 32'd1);
    if (sdat.size() >= 10)
      for (int i = 0; i < 10; i++) begin
        chk($sformatf("lp_d%0d", i), sdat[i], (i % 2) ? 32'h55 : 32'hAA);
        if (i > 0) chk($sformatf("lp_sp%0d", i), scyc[i] - scyc[i-1], 2);
      end
    rd(4'd2, r); chk("lp_nodone", {31'd0, r[8]}, 32'd0);

    // Abort one cycle after a strobe
    k = 0;
    while (k < 8 && !pio_chipselect) begin
      @(negedge clk);
      k++;
    end
    chk("ab_sync", {31'd0, pio_chipselect}, 32'd1);
    @(negedge clk);
    n0 = sdat.size();
    wr(4'd0, 32'h00);
    repeat (10) @(negedge clk);
    chk("ab_nostrobe", sdat.size(), n0);
    rd(4'd2, r); chk("ab_status", r, 32'h000);
    rd(4'd0, r); chk("ab_ctrl", r, 32'h000);

    // Asynchronous reset during WAIT of a looping run
    wr(4'd1, 32'd5);
    wr(4'd0, 32'h03);
    repeat (2) @(negedge clk);
    chk("rs_wd_hold", pio_writedata, 32'hAA);
    rd(4'd2, r); chk("rs_busy", r, 32'h001);
    reset_n = 1'b0;
    #1;
    chk("rs_cs", {31'd0, pio_chipselect}, 32'd0);
    chk("rs_wn", {31'd0, pio_write_n}, 32'd1);
    chk("rs_wd", pio_writedata, 32'd0);
    rd(4'd0, r); chk("rs_ctrl", r, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    n0 = sdat.size();
    repeat (20) @(negedge clk);
    chk("rs_nostrobe", sdat.size(), n0);
    rd(4'd2, r); chk("rs_status", r, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
